sort_frame_loader: RTL and testbench

Upstream feeder for the 4-input bubble-pass sorter stage. It accepts a serial stream of signed N-bit samples over a valid/ready handshake and assembles them into 4-word frames in a fill buffer. Each frame is transferred into output registers wired to the sorter's `i1..i4`, then held stable for `SETTLE` cycles so the clocked swapper chain can settle. Double buffering lets the next frame fill while the current one is held.

---
 rtl/sort_frame_loader.sv | 105 ++++++++++
 tb/tb_sort_frame_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_frame_loader.sv
// Serial-to-frame loader for the 4-input sorter: fills 4-word frames and holds each for SETTLE cycles.
// Optional short-frame padding on in_last is enabled by defining LOADER_PAD_EN.
module sort_frame_loader #(
    parameter int N      = 8,
    parameter int SETTLE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    output logic signed [N-1:0] f1,
    output logic signed [N-1:0] f2,
    output logic signed [N-1:0] f3,
    output logic signed [N-1:0] f4,
    output logic                frame_valid,
    output logic                frame_start,
    output logic                frame_done
);

    localparam logic [7:0] HOLD_LAST = 8'(SETTLE - 1);

    logic signed [N-1:0] b [4];
    logic [2:0]          cnt;
    logic                buf_full;
    logic                hold_active;
    logic [7:0]          hold_cnt;
    logic                accept;
    logic                xfer;
    logic                hold_end;
    logic                fill_done;

    assign in_ready = !buf_full;
    assign accept   = in_valid && in_ready;
    assign hold_end = hold_active && (hold_cnt == HOLD_LAST);
    assign xfer     = buf_full && (!hold_active || hold_end);

`ifdef LOADER_PAD_EN
    localparam logic signed [N-1:0] PAD_VAL = {1'b1, {(N-1){1'b0}}};

    // Slots beyond the words actually received take the most negative value.
    function automatic logic signed [N-1:0] pad_slot(input logic [2:0] idx,
                                                     input logic [2:0] fill,
                                                     input logic signed [N-1:0] data);
        return (idx < fill) ? data : PAD_VAL;
    endfunction

    assign fill_done = (cnt == 3'd3) || in_last;
`else
    logic unused_last;
    assign unused_last = in_last;
    assign fill_done   = (cnt == 3'd3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 3'd0;
            buf_full    <= 1'b0;
            hold_active <= 1'b0;
            hold_cnt    <= 8'd0;
            f1          <= '0;
            f2          <= '0;
            f3          <= '0;
            f4          <= '0;
            for (int i = 0; i < 4; i++) b[i] <= '0;
        end else begin
            // fill stage -> hold stage transfer
            if (xfer) begin
`ifdef LOADER_PAD_EN
                f1 <= pad_slot(3'd0, cnt, b[0]);
                f2 <= pad_slot(3'd1, cnt, b[1]);
                f3 <= pad_slot(3'd2, cnt, b[2]);
                f4 <= pad_slot(3'd3, cnt, b[3]);
`else
                f1 <= b[0];
                f2 <= b[1];
                f3 <= b[2];
                f4 <= b[3];
`endif
                cnt      <= 3'd0;
                buf_full <= 1'b0;
            end else if (accept) begin
                b[cnt[1:0]] <= in_data;
                cnt         <= cnt + 3'd1;
                buf_full    <= fill_done;
            end

            // hold stage
            if (xfer) begin
                hold_active <= 1'b1;
                hold_cnt    <= 8'd0;
            end else if (hold_end) begin
                hold_active <= 1'b0;
            end else if (hold_active) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign frame_valid = hold_active;
    assign frame_start = hold_active && (hold_cnt == 8'd0);
    assign frame_done  = hold_end;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed bench for sort_frame_loader: SETTLE=3 instance for timing/reset/pad cases,
// SETTLE=8 instance for back-to-back streaming and backpressure.
module tb_sort_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready;
    logic [7:0] f1, f2, f3, f4;
    logic       frame_valid, frame_start, frame_done;

    logic [7:0] d8;
    logic       v8, l8, rdy8;
    logic [7:0] g1, g2, g3, g4;
    logic       fv8, st8, dn8;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [31:0] q[$];
    logic [31:0] q8[$];

    int rises8 = 0, starts8 = 0, dones8 = 0, bp_seen = 0;

    sort_frame_loader #(.N(8), .SETTLE(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .f1(f1), .f2(f2), .f3(f3), .f4(f4),
        .frame_valid(frame_valid), .frame_start(frame_start), .frame_done(frame_done)
    );

    sort_frame_loader #(.N(8), .SETTLE(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(rdy8),
        .in_last(l8), .f1(g1), .f2(g2), .f3(g3), .f4(g4),
        .frame_valid(fv8), .frame_start(st8), .frame_done(dn8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic last);
        int k;
        in_valid = 1'b1;
        in_data  = d[7:0];
        in_last  = last;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        step();
    endtask

    task automatic send8(input int d);
        int k;
        v8 = 1'b1;
        d8 = d[7:0];
        l8 = 1'b0;
        k = 0;
        while (!rdy8 && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) check("send8_ready_timeout", {31'd0, rdy8}, 32'd1);
        step();
    endtask

    task automatic drain();
        int k = 0;
        while ((q.size() != 0 || frame_valid) && k < 60) begin
            step();
            k++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    // Scoreboard for the SETTLE=3 instance
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && frame_start) begin
                if (q.size() == 0) check("unexpected_frame_start", {31'd0, frame_start}, 32'd0);
                else check("sb_frame", {f1, f2, f3, f4}, q.pop_front());
            end
        end
    end

    // Scoreboard plus continuity/backpressure monitor for the SETTLE=8 instance
    initial begin
        logic fv_prev = 1'b0;
        logic stall = 1'b0, stall_fv = 1'b0, last_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fv_prev = 1'b0;
                stall = 1'b0;
                stall_fv = 1'b0;
            end else begin
                if (fv8 && !fv_prev) rises8++;
                fv_prev = fv8;
                if (st8) starts8++;
                if (dn8) dones8++;
                if (st8) begin
                    if (q8.size() == 0) check("unexpected_frame_start8", {31'd0, st8}, 32'd0);
                    else check("sb_frame8", {g1, g2, g3, g4}, q8.pop_front());
                end
                if (v8 && !rdy8) begin
                    stall = 1'b1;
                    stall_fv = stall_fv | fv8;
                    last_done = dn8;
                end else if (stall && v8 && rdy8) begin
                    if (stall_fv) begin
                        check("bp_release_after_done", {31'd0, last_done}, 32'd1);
                        bp_seen++;
                    end
                    stall = 1'b0;
                    stall_fv = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w[4];
        int k;
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
        v8 = 1'b0; d8 = 8'd0; l8 = 1'b0;
        step();
        step();

        // Reset values
        check("rst_f", {f1, f2, f3, f4}, 32'd0);
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_frame_start", {31'd0, frame_start}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        step();

        // First frame, cycle-exact timing
        w = '{5, -3, 7, 0};
        q.push_back(mk(5, -3, 7, 0));
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = w[i][7:0];
            step();
        end
        in_valid = 1'b0;
        check("t1_ready_low", {31'd0, in_ready}, 32'd0);
        check("t1_fv_not_yet", {31'd0, frame_valid}, 32'd0);
        step();
        check("t1_ready_back", {31'd0, in_ready}, 32'd1);
        check("t1_fv_c1", {31'd0, frame_valid}, 32'd1);
        check("t1_start_c1", {31'd0, frame_start}, 32'd1);
        check("t1_done_c1", {31'd0, frame_done}, 32'd0);
        check("t1_f", {f1, f2, f3, f4}, mk(5, -3, 7, 0));
        step();
        check("t1_fv_c2", {31'd0, frame_valid}, 32'd1);
        check("t1_start_c2", {31'd0, frame_start}, 32'd0);
        check("t1_done_c2", {31'd0, frame_done}, 32'd0);
        step();
        check("t1_fv_c3", {31'd0, frame_valid}, 32'd1);
        check("t1_done_c3", {31'd0, frame_done}, 32'd1);
        check("t1_start_c3", {31'd0, frame_start}, 32'd0);
        step();
        check("t1_fv_after", {31'd0, frame_valid}, 32'd0);
        check("t1_done_after", {31'd0, frame_done}, 32'd0);
        check("t1_f_kept", {f1, f2, f3, f4}, mk(5, -3, 7, 0));

        // Reset with a partial fill; inputs during reset are ignored
        send(1, 1'b0);
        send(2, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd55;
        step();
        check("mr_f", {f1, f2, f3, f4}, 32'd0);
        check("mr_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("mr_frame_start", {31'd0, frame_start}, 32'd0);
        check("mr_frame_done", {31'd0, frame_done}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        q.push_back(mk(9, 8, 7, 6));
        send(9, 1'b0);
        send(8, 1'b0);
        send(7, 1'b0);
        send(6, 1'b0);
        in_valid = 1'b0;
        drain();
        check("mr_f_kept", {f1, f2, f3, f4}, mk(9, 8, 7, 6));

        // Short frame with in_last
`ifdef LOADER_PAD_EN
        q.push_back(mk(4, 2, -128, -128));
        send(4, 1'b0);
        send(2, 1'b1);
        in_valid = 1'b0;
        in_last = 1'b0;
        drain();
        check("last_f", {f1, f2, f3, f4}, mk(4, 2, -128, -128));
`else
        q.push_back(mk(4, 2, 1, 1));
        send(4, 1'b0);
        send(2, 1'b1);
        send(1, 1'b0);
        send(1, 1'b0);
        in_valid = 1'b0;
        in_last = 1'b0;
        drain();
        check("last_f", {f1, f2, f3, f4}, mk(4, 2, 1, 1));
`endif

        // Back-to-back stream into the SETTLE=8 instance (covers backpressure)
        for (int fr = 0; fr < 3; fr++)
            q8.push_back(mk(fr * 40 - 50, fr * 40 - 37, fr * 40 - 24, fr * 40 - 11));
        for (int i = 0; i < 12; i++)
            send8((i / 4) * 40 - 50 + (i % 4) * 13);
        v8 = 1'b0;
        k = 0;
        while ((q8.size() != 0 || fv8) && k < 100) begin
            step();
            k++;
        end
        check("b2b_queue_empty", q8.size(), 0);
        check("b2b_fv_rises", rises8, 1);
        check("b2b_starts", starts8, 3);
        check("b2b_dones", dones8, 3);
        check("bp_release_seen", bp_seen, 1);
        check("b2b_last_f", {g1, g2, g3, g4}, mk(30, 43, 56, 69));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
